// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types and memory-model constants.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  localparam int unsigned MEM_RESP_LATENCY = 4;

endpackage

// File: rtl/responder_array.sv
// Word storage for mem_responder: byte-lane synchronous write, combinational read, no reset.
module responder_array
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  lc3b_word             wdata,
  input  lc3b_mem_wmask        wmask,
  output lc3b_word             rdata
);

  localparam int unsigned Words = 2 ** ADDR_BITS;

  lc3b_word mem [Words];

  always_ff @(posedge clk) begin
    if (we) begin
      if (wmask[0]) mem[addr][7:0]  <= wdata[7:0];
      if (wmask[1]) mem[addr][15:8] <= wdata[15:8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: latches one request, pulses mem_resp LATENCY cycles later.
module mem_responder
  import lc3b_types::*;
#(
  parameter int unsigned LATENCY   = MEM_RESP_LATENCY,
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  input  lc3b_mem_wmask mem_byte_enable,
  output logic          mem_resp,
  output lc3b_word      mem_rdata,
  output logic          busy,
  output logic          protocol_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  // Acceptance cycle and RESP cycle account for two of the LATENCY cycles.
  localparam logic [3:0] BusyLoad = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_e               state_q;
  logic [3:0]           count_q;
  logic [ADDR_BITS-1:0] idx_q;
  lc3b_word             wdata_q;
  lc3b_mem_wmask        mask_q;
  logic                 write_q;
  logic                 resp_q;
  logic                 busy_q;
  logic                 perr_q;

  logic     req;
  logic     array_we;
  lc3b_word array_rdata;
  logic     unused_addr_bits;

  assign req              = mem_read | mem_write;
  assign unused_addr_bits = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            idx_q   <= mem_address[ADDR_BITS:1];
            wdata_q <= mem_wdata;
            mask_q  <= mem_byte_enable;
            write_q <= mem_write;
            if (mem_read && mem_write) perr_q <= 1'b1;
            if (LATENCY > 1) begin
              state_q <= BUSY;
              count_q <= BusyLoad;
              busy_q  <= 1'b1;
            end else begin
              state_q <= RESP;
              resp_q  <= 1'b1;
            end
          end
        end
        BUSY: begin
          // Requester must hold its strobe; a drop is flagged but the transaction still completes.
          if (!req) perr_q <= 1'b1;
          if (count_q == 4'd0) begin
            state_q <= RESP;
            resp_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            count_q <= count_q - 4'd1;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // A reset asserted on the closing edge of RESP must still suppress the write.
  assign array_we = rst_n && (state_q == RESP) && write_q;

  responder_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk  (clk),
    .we   (array_we),
    .addr (idx_q),
    .wdata(wdata_q),
    .wmask(mask_q),
    .rdata(array_rdata)
  );

  assign mem_resp     = resp_q;
  assign mem_rdata    = (state_q == RESP && !write_q) ? array_rdata : 16'h0000;
  assign busy         = busy_q;
  assign protocol_err = perr_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 4: cycles from first request cycle to mem_resp; legal range 1..15.
REQ-002 Parameter ADDR_BITS, default 8: log2 of word count in storage (256 words).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 mem_read  input  1  read request strobe, held by requester until mem_resp.
REQ-006 mem_write  input  1  write request strobe, held by requester until mem_resp.
REQ-007 mem_address  input  lc3b_word  byte address; word index = mem_address[ADDR_BITS:1], bit 0 ignored, upper bits ignored.
REQ-008 mem_wdata  input  lc3b_word  write data.
REQ-009 mem_byte_enable  input  lc3b_mem_wmask  bit0 enables [7:0], bit1 enables [15:8].
REQ-010 mem_resp  output  1  one-cycle completion pulse.
REQ-011 mem_rdata  output  lc3b_word  read data, valid only while mem_resp=1 for a read.
REQ-012 busy  output  1  high in every cycle in which a transaction is latched but mem_resp has not yet pulsed.
REQ-013 protocol_err  output  1  sticky flag for requester protocol violations.

Function
REQ-014 FSM states SHALL be IDLE, BUSY, RESP.
REQ-015 In IDLE, a cycle with mem_read|mem_write SHALL latch address, wdata, byte enable and op; next state BUSY if LATENCY>1, else RESP.
REQ-016 mem_read and mem_write both high at acceptance SHALL be treated as a write and SHALL set protocol_err.
REQ-017 BUSY SHALL load a down-counter with LATENCY-2 on entry, decrement each cycle, and move to RESP when the counter is 0.
REQ-018 Request first high in cycle t SHALL produce mem_resp=1 in exactly cycle t+LATENCY.
REQ-019 RESP SHALL drive mem_resp=1 for exactly one cycle, then return to IDLE.
REQ-020 Write: storage SHALL update at the clock edge ending the RESP cycle, only for enabled byte lanes; a mask of 2'b00 writes nothing but still responds.
REQ-021 Read: mem_rdata in RESP SHALL equal the stored word at the latched index; outside RESP it SHALL be 16'h0000.
REQ-022 Input changes during BUSY/RESP SHALL be ignored; latched values SHALL be used.
REQ-023 Strobes dropping to 0 during BUSY SHALL NOT abort the transaction; it completes normally and sets protocol_err.
REQ-024 A request present in the cycle immediately after RESP SHALL be accepted as a new transaction (back-to-back allowed; no dead cycle required).
REQ-025 protocol_err SHALL clear only on reset.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force IDLE, counter=0, mem_resp=0, mem_rdata=0, busy=0, protocol_err=0.
REQ-027 Reset mid-transaction SHALL discard the pending transaction; a pending write SHALL NOT modify storage.
REQ-028 Storage contents SHALL NOT be reset.

Structure
REQ-029 lc3b_word and lc3b_mem_wmask SHALL come from lc3b_types; the default latency constant SHALL be added to lc3b_types.
REQ-030 State enum SHALL be local to the module.
REQ-031 Storage SHALL be one sub-module, responder_array: synchronous byte-lane write, combinational read, no reset.

Verification
REQ-032 Reset, write 0x1234 to 0x0010 with mask 11 -> mem_resp exactly 4 cycles after strobe; read 0x0010 -> rdata 0x1234 in resp cycle.
REQ-033 Word 0x0020 = 0xAAAA, write 0x5566 with mask 01 -> read returns 0xAA66; mask 10 with 0x5566 -> 0x55AA from 0xAAAA.
REQ-034 LATENCY=1: read strobe in cycle t -> mem_resp in t+1; back-to-back reads of 0x0002 then 0x0004 -> two pulses two cycles apart, correct data each.
REQ-035 Read and write high together at 0x0030, wdata 0xBEEF -> treated as write, protocol_err=1; subsequent read returns 0xBEEF.
REQ-036 Write to 0x0040 started, rst_n=0 in cycle 2 of BUSY -> no mem_resp, busy=0; read 0x0040 returns the prior value.
REQ-037 Address changed to 0x0050 mid-BUSY on a read of 0x0040 -> returned data is from 0x0040; mem_rdata=0 in all non-resp cycles.
